// File: rtl/fp_alu_result_fifo.sv
// fp_alu_result_fifo: first-word-fall-through buffer for floating-point ALU
// results and their overflow flags. It has valid/ready on both sides, and it
// keeps a sticky overflow flag and a saturating overflow event counter for
// status readback.
module fp_alu_result_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_result,
    input  logic          in_overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic          out_overflow,
    output logic [AW:0]   count,
    output logic          sticky_overflow,
    input  logic          clear_sticky,
    output logic [CW-1:0] ovf_events
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] OVF_MAX    = {CW{1'b1}};

    // Each storage word is {overflow, result}.
    logic [W:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          sticky_r;
    logic [CW-1:0] ovf_cnt_r;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_push_s;
    logic [AW:0]   count_nxt_s;
    logic          sticky_nxt_s;
    logic [CW-1:0] ovf_cnt_nxt_s;

    // Full and empty come from the occupancy count. When the FIFO is full,
    // a push is refused even if a pop happens in the same cycle.
    assign in_ready_s  = (count_r != FULL_COUNT);
    assign out_valid_s = (count_r != {(AW + 1){1'b0}});
    assign push_s      = in_valid && in_ready_s && !rst;
    assign pop_s       = out_valid_s && out_ready && !rst;
    assign ovf_push_s  = push_s && in_overflow;

    // Handshake qualification and next-state values for occupancy and status.
    always_comb begin
        count_nxt_s   = count_r;
        sticky_nxt_s  = sticky_r;
        ovf_cnt_nxt_s = ovf_cnt_r;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase

        // An overflow push in the same cycle as a clear takes priority.
        if (ovf_push_s) begin
            sticky_nxt_s = 1'b1;
        end else if (clear_sticky) begin
            sticky_nxt_s = 1'b0;
        end else begin
            sticky_nxt_s = sticky_r;
        end

        // A clear plus an overflow push gives 1. Otherwise the counter saturates.
        if (clear_sticky && ovf_push_s) begin
            ovf_cnt_nxt_s = CW'(1);
        end else if (clear_sticky) begin
            ovf_cnt_nxt_s = {CW{1'b0}};
        end else if (ovf_push_s && (ovf_cnt_r != OVF_MAX)) begin
            ovf_cnt_nxt_s = ovf_cnt_r + CW'(1);
        end else begin
            ovf_cnt_nxt_s = ovf_cnt_r;
        end
    end

    // Pointer, occupancy and status registers. These are cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW + 1){1'b0}};
            sticky_r  <= 1'b0;
            ovf_cnt_r <= {CW{1'b0}};
        end else begin
            // The pointers wrap naturally because DEPTH is a power of two.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r   <= count_nxt_s;
            sticky_r  <= sticky_nxt_s;
            ovf_cnt_r <= ovf_cnt_nxt_s;
        end
    end

    // Entry storage. It is not reset because contents are only read while valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_overflow, in_result};
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_s;
    assign out_overflow    = mem_r[rd_ptr_r][W];
    assign out_result      = mem_r[rd_ptr_r][W-1:0];
    assign count           = count_r;
    assign sticky_overflow = sticky_r;
    assign ovf_events      = ovf_cnt_r;

endmodule

// File: tb/tb_fp_alu_result_fifo.sv
// Bench for fp_alu_result_fifo. The stimulus is directed and runs with CW=2,
// so counter saturation can be reached. Each accepted push queues its
// expected head word, and a monitor compares every popped head in order.
module tb_fp_alu_result_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic          in_overflow;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_overflow;
    logic [AW:0]   count;
    logic          sticky_overflow;
    logic          clear_sticky;
    logic [CW-1:0] ovf_events;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q [$];

    fp_alu_result_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .count(count), .sticky_overflow(sticky_overflow),
        .clear_sticky(clear_sticky), .ovf_events(ovf_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one push. When accept is set, also queue the expected head word.
    task automatic drive_push(input logic [W-1:0] d, input logic ovf, input bit accept);
        in_valid    = 1'b1;
        in_result   = d;
        in_overflow = ovf;
        if (accept) exp_q.push_back({ovf, d});
    endtask

    // Monitor. It samples on the falling edge and checks each head that is popped.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_unexpected: got %0h expected none", {out_overflow, out_result});
            end else begin
                chk("head", 64'({out_overflow, out_result}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
        out_ready = 1'b0; clear_sticky = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Check the state after reset.
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sticky", 64'(sticky_overflow), 64'd0);
        chk("rst_events", 64'(ovf_events), 64'd0);

        // A single push becomes visible one cycle later, then one pop.
        drive_push(32'h3F800000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_result", 64'(out_result), 64'h3F800000);
        chk("single_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_count", 64'(count), 64'd0);
        chk("single_pop_valid", 64'(out_valid), 64'd0);

        // Fill to full, then push while full (ignored), then drain.
        for (int i = 1; i <= 4; i++) begin
            drive_push(32'h11111111 * i, 1'b0, 1'b1);
            tick();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive_push(32'h55555555, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("full_push_ignored", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Stream continuously. The count holds at 1 and the pointers wrap.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive_push(32'(i), 1'b0, 1'b1);
            tick();
            chk("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);

        // Sticky flag and event counter behaviour.
        drive_push(32'hA0000001, 1'b1, 1'b1); tick();
        drive_push(32'hA0000002, 1'b0, 1'b1); tick();
        drive_push(32'hA0000003, 1'b1, 1'b1); tick();
        in_valid = 1'b0;
        chk("ovf_sticky", 64'(sticky_overflow), 64'd1);
        chk("ovf_events2", 64'(ovf_events), 64'd2);
        chk("ovf_head_flag", 64'(out_overflow), 64'd1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        clear_sticky = 1'b1;
        drive_push(32'hA0000004, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("clr_push_sticky", 64'(sticky_overflow), 64'd1);
        chk("clr_push_events", 64'(ovf_events), 64'd1);
        tick();
        clear_sticky = 1'b0;
        chk("clr_sticky", 64'(sticky_overflow), 64'd0);
        chk("clr_events", 64'(ovf_events), 64'd0);
        out_ready = 1'b1;
        tick();

        // The event counter saturates at 3 when CW=2.
        for (int i = 1; i <= 5; i++) begin
            drive_push(32'hB0000000 + 32'(i), 1'b1, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        chk("sat_events", 64'(ovf_events), 64'd3);
        tick();
        out_ready = 1'b0;
        chk("all_heads_seen", 64'(exp_q.size()), 64'd0);

        // Reset during operation discards the entries and ignores any handshake.
        for (int i = 1; i <= 3; i++) begin
            drive_push(32'hC0000000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b1;
        drive_push(32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_events", 64'(ovf_events), 64'd0);
        chk("mid_rst_sticky", 64'(sticky_overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_alu_result_fifo.md
Name: fp_alu_result_fifo

Overview:
- Downstream stage of the floating-point ALU. Buffers each ALU result together with its overflow flag in a small first-word-fall-through (FWFT) FIFO, with valid/ready handshakes on both sides.
- Keeps a sticky overflow flag and a saturating overflow event counter for status readback.
- Decouples the ALU's result timing from a consumer that may stall.

Parameters:
- W, 32, result word width (matches the ALU operand/result width)
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
- AW, 2, address width = log2(DEPTH)
- CW, 8, width of the overflow event counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  ALU result present on in_result/in_overflow
- in_ready  output  1  FIFO can accept an entry this cycle
- in_result  input  W  signed ALU result
- in_overflow  input  1  overflow flag accompanying in_result
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes the head entry this cycle
- out_result  output  W  head entry result
- out_overflow  output  1  head entry overflow flag
- count  output  AW+1  current occupancy, range 0..DEPTH
- sticky_overflow  output  1  set when any accepted entry carried overflow
- clear_sticky  input  1  clears sticky_overflow and ovf_events
- ovf_events  output  CW  saturating count of accepted entries that had overflow=1

Behaviour:
- Reset (rst=1 at a clock edge):
  - write pointer, read pointer, count, sticky_overflow and ovf_events go to 0.
  - out_valid=0 and in_ready=1 from the first cycle after reset.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries; any handshake asserted in the reset cycle is ignored.
- Push: occurs when in_valid && in_ready. Writes {in_overflow, in_result} at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: occurs when out_valid && out_ready. Increments the read pointer modulo DEPTH.
- Flags:
  - in_ready = (count != DEPTH). No write-through when full: a same-cycle pop at full does not allow a push.
  - out_valid = (count != 0).
- FWFT head: out_result and out_overflow are driven combinationally from the entry at the read pointer. They are stable while out_valid=1 and no pop occurs. When out_valid=0 their value is don't-care.
- Latency: a push into an empty FIFO makes out_valid=1 in the next cycle. There is no same-cycle bypass.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (only possible when 0 < count < DEPTH).
- Pointers wrap from DEPTH-1 to 0. Full versus empty is determined by count, not by pointer equality.
- sticky_overflow:
  - Sets on a push with in_overflow=1.
  - Clears on clear_sticky=1.
  - If both happen in the same cycle, set wins: the result is 1.
- ovf_events:
  - Increments on a push with in_overflow=1 and saturates at 2^CW-1 (no wrap).
  - clear_sticky resets it to 0.
  - If clear and an overflow push happen in the same cycle, the result is 1.
- Pushes while full and pops while empty are ignored: no state change and no error.
- in_result is treated as opaque bits. There is no arithmetic on the data path.

Test Plan:
- Reset then idle -> count=0, out_valid=0, in_ready=1, sticky_overflow=0, ovf_events=0.
- Push 0x3F800000 (ovf=0) with out_ready=0 -> next cycle out_valid=1, out_result=0x3F800000, count=1. Pop -> count=0, out_valid=0.
- Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=0 -> count=4, in_ready=0. A 5th push of 0x55555555 with in_valid=1 is ignored. Drain -> outputs appear in the order 0x11111111..0x44444444, and 0x55555555 never appears.
- Continuous streaming, in_valid=1 and out_ready=1 for 10 cycles with incrementing data 1..10 -> count holds at 1 after the first cycle. Data comes out in order 1..10 with one cycle of latency, and the pointers wrap twice without loss.
- Push entries with overflow=1,0,1 -> sticky_overflow=1, ovf_events=2. Head entries show out_overflow=1,0,1. Assert clear_sticky in the same cycle as another overflow push -> sticky_overflow=1, ovf_events=1.
- With CW=2, push 5 overflow entries (draining as needed) -> ovf_events saturates at 3. Assert rst with count=3 -> next cycle count=0, out_valid=0, in_ready=1, ovf_events=0.
